// File: rtl/paddle_mover.sv
// rtl/paddle_mover.sv - frame-synchronous accelerating paddle with clamped position and registered draw flag
module paddle_mover #(
  parameter int LEN         = 2,
  parameter int WID         = 94,
  parameter int X0          = 20,
  parameter int Y0          = 193,
  parameter int ORIENT      = 0,
  parameter int MIN_POS     = 0,
  parameter int MAX_POS     = 479,
  parameter int STEP_MIN    = 1,
  parameter int STEP_MAX    = 8,
  parameter int ACCEL_TICKS = 4
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        mv_neg,
  input  logic        mv_pos,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  output logic [10:0] x1,
  output logic [10:0] y1,
  output logic [10:0] x2,
  output logic [10:0] y2,
  output logic        draw,
  output logic        moving
);

  localparam int EXT = (ORIENT != 0) ? LEN : WID;
  localparam int HW  = $clog2(ACCEL_TICKS + 1);
  localparam logic signed [12:0] MIN_S = 13'(MIN_POS);
  localparam logic signed [12:0] MAX_S = 13'(MAX_POS);
  localparam logic signed [12:0] EXT_S = 13'(EXT);

  typedef enum logic [1:0] {IDLE, RUN_NEG, RUN_POS} state_t;

  state_t             state, state_nxt;
  logic [10:0]        step, step_nxt, mv_step;
  logic [HW-1:0]      hold, hold_nxt;
  logic [10:0]        pos, pos_nxt, x1_nxt, y1_nxt;
  logic               req_neg, req_pos;
  logic signed [12:0] pos_s, cand;

  assign pos     = (ORIENT != 0) ? x1 : y1;
  assign req_neg = mv_neg & ~mv_pos;
  assign req_pos = mv_pos & ~mv_neg;
  assign moving  = (state != IDLE);

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    hold_nxt  = hold;
    mv_step   = step;
    pos_s     = signed'({2'b00, pos});
    cand      = pos_s;
    pos_nxt   = pos;
    if (frame_tick) begin
      if (!req_neg && !req_pos) begin
        state_nxt = IDLE;
        step_nxt  = 11'(STEP_MIN);
        hold_nxt  = '0;
      end else begin
        if ((req_neg && state != RUN_NEG) || (req_pos && state != RUN_POS)) begin
          state_nxt = req_neg ? RUN_NEG : RUN_POS;
          mv_step   = 11'(STEP_MIN);
          step_nxt  = 11'(STEP_MIN);
          hold_nxt  = HW'(1);
        end else if (hold + HW'(1) == HW'(ACCEL_TICKS)) begin
          hold_nxt = '0;
          step_nxt = (step >= 11'(STEP_MAX)) ? 11'(STEP_MAX) : step + 11'd1;
        end else begin
          hold_nxt = hold + HW'(1);
        end
        // Signed 13-bit sum keeps the range checks free of wrap at 0 and 2047
        if (req_neg) begin
          cand = pos_s - signed'({2'b00, mv_step});
          if (cand < MIN_S) begin
            cand     = MIN_S;
            step_nxt = 11'(STEP_MIN);
            hold_nxt = '0;
          end
        end else begin
          cand = pos_s + signed'({2'b00, mv_step});
          if (cand + EXT_S > MAX_S) begin
            cand     = MAX_S - EXT_S;
            step_nxt = 11'(STEP_MIN);
            hold_nxt = '0;
          end
        end
        pos_nxt = cand[10:0];
      end
    end
  end

  assign x1_nxt = (ORIENT != 0) ? pos_nxt : x1;
  assign y1_nxt = (ORIENT != 0) ? y1 : pos_nxt;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= 11'(STEP_MIN);
      hold  <= '0;
      x1    <= 11'(X0);
      y1    <= 11'(Y0);
      x2    <= 11'(X0 + LEN);
      y2    <= 11'(Y0 + WID);
      draw  <= 1'b0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      hold  <= hold_nxt;
      x1    <= x1_nxt;
      y1    <= y1_nxt;
      x2    <= x1_nxt + 11'(LEN);
      y2    <= y1_nxt + 11'(WID);
      // Compared against the corners held before this edge
      draw  <= (hcount >= x1) && (hcount <= x2) && (vcount >= y1) && (vcount <= y2);
    end
  end

endmodule

// File: tb/tb_paddle_mover.sv
// tb/tb_paddle_mover.sv - random and directed check of paddle_mover against an integer position model
module tb_paddle_mover;

  logic        pixel_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        mv_neg = 1'b0;
  logic        mv_pos = 1'b0;
  logic [10:0] hcount = '0;
  logic [10:0] vcount = '0;
  logic [10:0] v_x1, v_y1, v_x2, v_y2, h_x1, h_y1, h_x2, h_y2;
  logic        v_draw, v_moving, h_draw, h_moving;

  paddle_mover u_dut_v (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .mv_neg(mv_neg), .mv_pos(mv_pos), .hcount(hcount), .vcount(vcount),
    .x1(v_x1), .y1(v_y1), .x2(v_x2), .y2(v_y2), .draw(v_draw), .moving(v_moving)
  );

  paddle_mover #(.ORIENT(1), .X0(100), .LEN(80), .MAX_POS(639)) u_dut_h (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .mv_neg(mv_neg), .mv_pos(mv_pos), .hcount(hcount), .vcount(vcount),
    .x1(h_x1), .y1(h_y1), .x2(h_x2), .y2(h_y2), .draw(h_draw), .moving(h_moving)
  );

  always #5 pixel_clk = ~pixel_clk;

  int p_len[2] = '{2, 80};
  int p_wid[2] = '{94, 94};
  int p_x0[2]  = '{20, 100};
  int p_y0[2]  = '{193, 193};
  int p_or[2]  = '{0, 1};
  int p_max[2] = '{479, 639};

  int m_pos[2], m_step[2], m_hold[2], m_dir[2], m_draw[2];
  int n_chk = 0;
  int n_fail = 0;

  function automatic int mx1(int k);
    return (p_or[k] != 0) ? m_pos[k] : p_x0[k];
  endfunction

  function automatic int my1(int k);
    return (p_or[k] != 0) ? p_y0[k] : m_pos[k];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pos[k]  = (p_or[k] != 0) ? p_x0[k] : p_y0[k];
      m_step[k] = 1;
      m_hold[k] = 0;
      m_dir[k]  = 0;
      m_draw[k] = 0;
    end
  endtask

  task automatic model_adv(input int k, input bit tick, input bit n, input bit p, input int h, input int v);
    int req, s, np, e;
    m_draw[k] = (h >= mx1(k) && h <= mx1(k) + p_len[k] && v >= my1(k) && v <= my1(k) + p_wid[k]) ? 1 : 0;
    if (!tick) return;
    req = (n && !p) ? -1 : ((p && !n) ? 1 : 0);
    e = (p_or[k] != 0) ? p_len[k] : p_wid[k];
    if (req == 0) begin
      m_dir[k] = 0; m_step[k] = 1; m_hold[k] = 0;
      return;
    end
    if (req != m_dir[k]) begin
      m_dir[k] = req; s = 1; m_step[k] = 1; m_hold[k] = 1;
    end else begin
      s = m_step[k];
      m_hold[k]++;
      if (m_hold[k] == 4) begin
        m_hold[k] = 0;
        m_step[k] = (m_step[k] + 1 > 8) ? 8 : m_step[k] + 1;
      end
    end
    np = m_pos[k] + req * s;
    if (np < 0 || np + e > p_max[k]) begin
      np = (np < 0) ? 0 : p_max[k] - e;
      m_step[k] = 1; m_hold[k] = 0;
    end
    m_pos[k] = np;
  endtask

  task automatic compare_all();
    chk("v_x1", v_x1, mx1(0));
    chk("v_y1", v_y1, my1(0));
    chk("v_x2", v_x2, mx1(0) + p_len[0]);
    chk("v_y2", v_y2, my1(0) + p_wid[0]);
    chk("v_draw", v_draw, m_draw[0]);
    chk("v_moving", v_moving, (m_dir[0] != 0) ? 1 : 0);
    chk("h_x1", h_x1, mx1(1));
    chk("h_y1", h_y1, my1(1));
    chk("h_x2", h_x2, mx1(1) + p_len[1]);
    chk("h_y2", h_y2, my1(1) + p_wid[1]);
    chk("h_draw", h_draw, m_draw[1]);
    chk("h_moving", h_moving, (m_dir[1] != 0) ? 1 : 0);
  endtask

  // Called at posedge+1; drives one cycle of inputs and checks the result after the next edge
  task automatic cycle(input bit tick, input bit n, input bit p, input int h, input int v);
    frame_tick = tick;
    mv_neg     = n;
    mv_pos     = p;
    hcount     = 11'(h);
    vcount     = 11'(v);
    model_adv(0, tick, n, p, h, v);
    model_adv(1, tick, n, p, h, v);
    @(posedge pixel_clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_v_x1", v_x1, 20);
    chk("rst_v_y1", v_y1, 193);
    chk("rst_v_x2", v_x2, 22);
    chk("rst_v_y2", v_y2, 287);
    chk("rst_v_draw", v_draw, 0);
    chk("rst_v_moving", v_moving, 0);
    chk("rst_h_x1", h_x1, 100);
    chk("rst_h_x2", h_x2, 180);
    model_reset();
    @(posedge pixel_clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int accel_exp[5] = '{194, 195, 196, 197, 199};
    int guard;
    logic [1:0] btn;

    @(posedge pixel_clk);
    #1;
    do_reset();

    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 0, 0);
      chk("accel_y1", v_y1, accel_exp[i]);
    end
    chk("accel_moving", v_moving, 1);
    chk("accel_x1", v_x1, 20);

    guard = 0;
    while (v_y1 != 11'd385 && guard < 200) begin
      cycle(1'b1, 1'b0, 1'b1, 0, 0);
      guard++;
    end
    chk("clamp_reached_y1", v_y1, 385);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 0, 0);
      chk("clamp_hold_y1", v_y1, 385);
      chk("clamp_hold_y2", v_y2, 479);
    end
    cycle(1'b0, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, 1'b1, 1'b0, 0, 0);
    chk("clamp_release_y1", v_y1, 384);

    cycle(1'b1, 1'b1, 1'b1, 0, 0);
    chk("conflict_moving", v_moving, 0);
    chk("conflict_y1", v_y1, 384);
    for (int i = 0; i < 10; i++) begin
      btn = 2'($urandom_range(0, 3));
      cycle(1'b0, btn[0], btn[1], 0, 0);
      chk("untick_y1", v_y1, 384);
    end

    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 22, 287);
    chk("draw_corner", v_draw, 1);
    cycle(1'b0, 1'b0, 1'b0, 23, 287);
    chk("draw_past_x2", v_draw, 0);
    cycle(1'b0, 1'b0, 1'b0, 22, 192);
    chk("draw_above_y1", v_draw, 0);

    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 0, 0);
      chk("horiz_x1", h_x1, 99 - i);
      chk("horiz_x2", h_x2, 179 - i);
      chk("horiz_y1", h_y1, 193);
    end

    btn = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      if ($urandom_range(0, 31) == 0) btn = 2'($urandom_range(0, 3));
      cycle($urandom_range(0, 3) == 0, btn[0], btn[1],
            int'($urandom_range(0, 220)), int'($urandom_range(0, 511)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
